dmem_master: RTL and testbench



---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_wait_ctr.sv | 27 ++
 rtl/dmem_master.sv | 108 ++++++++++
 tb/tb_dmem_master.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory bus initiator.
package dmem_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned LAT_W  = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        WAIT  = ST_WAIT,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/dmem_wait_ctr.sv
// Loadable down-counter timing the memory read wait; zero flags the last wait cycle.
module dmem_wait_ctr
    import dmem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [LAT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dmem_master.sv
// Sequential initiator for DATA_MEMORY: one load/store at a time via valid/ready.
// Optional address range check enabled by defining DMEM_MASTER_ADDR_CHECK_EN.
module dmem_master
    import dmem_pkg::*;
#(
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned MEM_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [BUS_W-1:0]  req_addr,
    input  logic [BUS_W-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [BUS_W-1:0]  Bus_A,
    output logic [BUS_W-1:0]  Bus_B,
    output logic              MW1,
    input  logic [DATA_W-1:0] data_out
);

    state_t state, state_next;
    logic   we_q, err_q;
    logic   accept_c, oob_c;
    logic   ctr_load, ctr_dec, ctr_zero;

    initial begin
        assert (READ_LAT >= 1 && READ_LAT <= 15 && MEM_DEPTH >= 1)
            else $fatal(1, "dmem_master: READ_LAT must be 1..15 and MEM_DEPTH nonzero");
    end

`ifdef DMEM_MASTER_ADDR_CHECK_EN
    assign oob_c = (req_addr >= BUS_W'(MEM_DEPTH));
`else
    assign oob_c = 1'b0;
`endif

    assign accept_c = (state == IDLE) && req_valid;

    dmem_wait_ctr u_wait_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ctr_load),
        .load_val (LAT_W'(READ_LAT - 1)),
        .dec      (ctr_dec),
        .zero     (ctr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ctr_load   = 1'b0;
        ctr_dec    = 1'b0;
        case (state)
            IDLE:  if (req_valid) state_next = SETUP;
            SETUP: begin
                ctr_load   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (ctr_zero) state_next = DONE;
                else          ctr_dec    = 1'b1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered bus and response outputs; the write strobe covers only the SETUP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            Bus_A     <= '0;
            Bus_B     <= '0;
            MW1       <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            req_ready <= (state_next == IDLE);
            rsp_valid <= (state_next == DONE);
            MW1       <= accept_c && req_we && !oob_c;
            if (accept_c) begin
                Bus_A <= req_addr;
                Bus_B <= req_wdata;
                we_q  <= req_we;
                err_q <= oob_c;
            end
            if ((state == WAIT) && ctr_zero) begin
                rsp_rdata <= (we_q || err_q) ? '0 : data_out;
                rsp_err   <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_master.sv
// Self-checking bench for dmem_master: scoreboarded responses plus bus/timing checks.
module tb_dmem_master;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, mw1;
    logic [15:0] rsp_rdata, data_out;
    logic [31:0] bus_a, bus_b;

    logic        r3_valid, r3_ready, r3_we;
    logic [31:0] r3_addr, r3_wdata;
    logic        r3_rsp_valid, r3_err, r3_mw1;
    logic [15:0] r3_rdata, r3_data_out;
    logic [31:0] r3_bus_a, r3_bus_b;

    logic [15:0] mem     [0:31];
    logic [15:0] ref_mem [0:31];

    int          checks, errors;
    int          mw1_cnt;
    logic [31:0] mw1_addr, mw1_data;

    logic [15:0] exp_rdata_q[$];
    logic [15:0] obs_rdata_q[$];
    logic        exp_err_q[$];
    logic        obs_err_q[$];

    dmem_master #(.READ_LAT(1), .MEM_DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .Bus_A(bus_a), .Bus_B(bus_b), .MW1(mw1), .data_out(data_out)
    );

    dmem_master #(.READ_LAT(3), .MEM_DEPTH(32)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(r3_valid), .req_ready(r3_ready), .req_we(r3_we),
        .req_addr(r3_addr), .req_wdata(r3_wdata),
        .rsp_valid(r3_rsp_valid), .rsp_rdata(r3_rdata), .rsp_err(r3_err),
        .Bus_A(r3_bus_a), .Bus_B(r3_bus_b), .MW1(r3_mw1), .data_out(r3_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DATA_MEMORY: 32 words, address aliases on the low 5 bits.
    assign data_out = mem[bus_a[4:0]];
    always @(posedge clk) if (mw1) mem[bus_a[4:0]] <= bus_b[15:0];

    always @(negedge clk) begin
        if (mw1) begin
            mw1_cnt++;
            mw1_addr = bus_a;
            mw1_data = bus_b;
        end
        if (rsp_valid) begin
            obs_rdata_q.push_back(rsp_rdata);
            obs_err_q.push_back(rsp_err);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Push the expected response for a request and update the reference memory.
    task automatic push_expect(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        logic oob;
`ifdef DMEM_MASTER_ADDR_CHECK_EN
        oob = (addr >= 32'd32);
`else
        oob = 1'b0;
`endif
        if (we) begin
            exp_rdata_q.push_back(16'h0000);
            if (!oob) ref_mem[addr[4:0]] = wdata[15:0];
        end else begin
            exp_rdata_q.push_back(oob ? 16'h0000 : ref_mem[addr[4:0]]);
        end
        exp_err_q.push_back(oob);
    endtask

    // Present one request, return edges from accept to rsp_valid and ready-high count while busy.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output int rdy_busy);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        push_expect(we, addr, wdata);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; rdy_busy = 0;
        while (!rsp_valid && lat < 40) begin
            if (req_ready) rdy_busy++;
            @(posedge clk); #1;
            lat++;
        end
        if (req_ready) rdy_busy++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", rsp_err); end
        checks++; if (bus_a !== 32'h0) begin errors++; $display("FAIL reset_bus_a got %h want 0", bus_a); end
        checks++; if (bus_b !== 32'h0) begin errors++; $display("FAIL reset_bus_b got %h want 0", bus_b); end
        checks++; if (mw1 !== 1'b0) begin errors++; $display("FAIL reset_mw1 got %b want 0", mw1); end
        checks++; if (r3_ready !== 1'b1) begin errors++; $display("FAIL reset_ready3 got %b want 1", r3_ready); end
    endtask

    task automatic test_store_load();
        int lat, rb;
        logic [15:0] e, o;
        logic ee, oe;
        mw1_cnt = 0;
        issue(1'b1, 32'd4, 32'd2, lat, rb);
        checks++; if (lat != 2) begin errors++; $display("FAIL store_latency got %0d want 2", lat); end
        checks++; if (rb != 0) begin errors++; $display("FAIL store_ready_busy got %0d want 0", rb); end
        checks++; if (mw1_cnt != 1) begin errors++; $display("FAIL store_mw1_cycles got %0d want 1", mw1_cnt); end
        checks++; if (mw1_addr !== 32'd4) begin errors++; $display("FAIL store_bus_a got %h want 4", mw1_addr); end
        checks++; if (mw1_data !== 32'd2) begin errors++; $display("FAIL store_bus_b got %h want 2", mw1_data); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_pulse_width got %b want 0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_done got %b want 1", req_ready); end
        issue(1'b0, 32'd4, 32'd0, lat, rb);
        checks++; if (lat != 2) begin errors++; $display("FAIL load_latency got %0d want 2", lat); end
        checks++; if (mw1_cnt != 1) begin errors++; $display("FAIL load_mw1_cycles got %0d want 1", mw1_cnt); end
        checks++; if (obs_rdata_q.size() != exp_rdata_q.size()) begin
            errors++; $display("FAIL store_load_rsp_count got %0d want %0d", obs_rdata_q.size(), exp_rdata_q.size());
        end
        while (exp_rdata_q.size() > 0 && obs_rdata_q.size() > 0) begin
            e = exp_rdata_q.pop_front(); o = obs_rdata_q.pop_front();
            ee = exp_err_q.pop_front(); oe = obs_err_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL store_load_rdata got %h want %h", o, e); end
            checks++; if (oe !== ee) begin errors++; $display("FAIL store_load_err got %b want %b", oe, ee); end
        end
        exp_rdata_q.delete(); obs_rdata_q.delete(); exp_err_q.delete(); obs_err_q.delete();
    endtask

    task automatic test_load_init();
        int lat, rb;
        logic [15:0] e, o;
        mw1_cnt = 0;
        issue(1'b0, 32'd9, 32'hDEAD_BEEF, lat, rb);
        checks++; if (mw1_cnt != 0) begin errors++; $display("FAIL load9_mw1_cycles got %0d want 0", mw1_cnt); end
        checks++; if (obs_rdata_q.size() != 1) begin errors++; $display("FAIL load9_rsp_count got %0d want 1", obs_rdata_q.size()); end
        while (exp_rdata_q.size() > 0 && obs_rdata_q.size() > 0) begin
            e = exp_rdata_q.pop_front(); o = obs_rdata_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL load9_rdata got %h want %h", o, e); end
        end
        exp_rdata_q.delete(); obs_rdata_q.delete(); exp_err_q.delete(); obs_err_q.delete();
    endtask

    task automatic test_back_to_back();
        int k, n;
        logic [15:0] e, o;
        mw1_cnt = 0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd5; req_wdata = 32'd7;
        push_expect(1'b1, 32'd5, 32'd7);
        @(posedge clk); #1;
        checks++; if (bus_a !== 32'd5 || bus_b !== 32'd7 || mw1 !== 1'b1) begin
            errors++; $display("FAIL b2b_first_setup got a=%h b=%h mw1=%b want 5 7 1", bus_a, bus_b, mw1);
        end
        req_addr = 32'd6; req_wdata = 32'd3;
        push_expect(1'b1, 32'd6, 32'd3);
        k = 0;
        while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
        checks++; if (k != 3) begin errors++; $display("FAIL b2b_ready_low_cycles got %0d want 3", k); end
        @(posedge clk); #1; k++;
        req_valid = 1'b0;
        checks++; if (k != 4) begin errors++; $display("FAIL b2b_accept_spacing got %0d want 4", k); end
        checks++; if (bus_a !== 32'd6 || bus_b !== 32'd3 || mw1 !== 1'b1) begin
            errors++; $display("FAIL b2b_second_setup got a=%h b=%h mw1=%b want 6 3 1", bus_a, bus_b, mw1);
        end
        n = 0;
        while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        checks++; if (mw1_cnt != 2) begin errors++; $display("FAIL b2b_mw1_cycles got %0d want 2", mw1_cnt); end
        checks++; if (obs_rdata_q.size() != 2) begin errors++; $display("FAIL b2b_rsp_count got %0d want 2", obs_rdata_q.size()); end
        while (exp_rdata_q.size() > 0 && obs_rdata_q.size() > 0) begin
            e = exp_rdata_q.pop_front(); o = obs_rdata_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL b2b_rdata got %h want %h", o, e); end
        end
        exp_rdata_q.delete(); obs_rdata_q.delete(); exp_err_q.delete(); obs_err_q.delete();
    endtask

    task automatic test_read_lat3();
        int k, mw;
        r3_valid = 1'b1; r3_we = 1'b0; r3_addr = 32'd4; r3_wdata = 32'd0;
        @(posedge clk); #1;
        r3_valid = 1'b0;
        k = 0; mw = 0;
        r3_data_out = 16'h1000;
        while (!r3_rsp_valid && k < 40) begin
            if (r3_mw1) mw++;
            @(posedge clk); #1;
            k++;
            r3_data_out = 16'h1000 + 16'(k);
        end
        checks++; if (k != 4) begin errors++; $display("FAIL lat3_latency got %0d want 4", k); end
        checks++; if (r3_rdata !== 16'h1003) begin errors++; $display("FAIL lat3_sample_edge got %h want 1003", r3_rdata); end
        checks++; if (r3_bus_a !== 32'd4) begin errors++; $display("FAIL lat3_bus_a got %h want 4", r3_bus_a); end
        checks++; if (mw != 0) begin errors++; $display("FAIL lat3_mw1 got %0d want 0", mw); end
        @(posedge clk); #1;
        checks++; if (r3_ready !== 1'b1) begin errors++; $display("FAIL lat3_ready_back got %b want 1", r3_ready); end
    endtask

    task automatic test_reset_mid();
        int lat, rb;
        logic [15:0] e, o;
        mw1_cnt = 0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd16; req_wdata = 32'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (mw1 !== 1'b1) begin errors++; $display("FAIL rstmid_setup_mw1 got %b want 1", mw1); end
        rst_n = 1'b0;
        #1;
        checks++; if (mw1 !== 1'b0) begin errors++; $display("FAIL rstmid_mw1_drop got %b want 0", mw1); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", req_ready); end
        checks++; if (bus_a !== 32'h0) begin errors++; $display("FAIL rstmid_bus_a got %h want 0", bus_a); end
        #2;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (obs_rdata_q.size() != 0) begin errors++; $display("FAIL rstmid_no_rsp got %0d want 0", obs_rdata_q.size()); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after got %b want 1", req_ready); end
        issue(1'b0, 32'd16, 32'd0, lat, rb);
        while (exp_rdata_q.size() > 0 && obs_rdata_q.size() > 0) begin
            e = exp_rdata_q.pop_front(); o = obs_rdata_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL rstmid_mem_intact got %h want %h", o, e); end
        end
        exp_rdata_q.delete(); obs_rdata_q.delete(); exp_err_q.delete(); obs_err_q.delete();
    endtask

    task automatic test_addr_check();
        int lat, rb, exp_mw;
        logic [15:0] e, o;
        logic ee, oe;
`ifdef DMEM_MASTER_ADDR_CHECK_EN
        exp_mw = 0;
`else
        exp_mw = 1;
`endif
        mw1_cnt = 0;
        issue(1'b1, 32'd40, 32'h55, lat, rb);
        checks++; if (lat != 2) begin errors++; $display("FAIL addr40_latency got %0d want 2", lat); end
        checks++; if (mw1_cnt != exp_mw) begin errors++; $display("FAIL addr40_mw1 got %0d want %0d", mw1_cnt, exp_mw); end
        issue(1'b0, 32'd8, 32'd0, lat, rb);
        checks++; if (obs_rdata_q.size() != 2) begin errors++; $display("FAIL addr_rsp_count got %0d want 2", obs_rdata_q.size()); end
        while (exp_rdata_q.size() > 0 && obs_rdata_q.size() > 0) begin
            e = exp_rdata_q.pop_front(); o = obs_rdata_q.pop_front();
            ee = exp_err_q.pop_front(); oe = obs_err_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL addr_rdata got %h want %h", o, e); end
            checks++; if (oe !== ee) begin errors++; $display("FAIL addr_err got %b want %b", oe, ee); end
        end
        exp_rdata_q.delete(); obs_rdata_q.delete(); exp_err_q.delete(); obs_err_q.delete();
    endtask

    initial begin
        checks = 0; errors = 0; mw1_cnt = 0;
        mw1_addr = '0; mw1_data = '0;
        for (int i = 0; i < 32; i++) begin
            mem[i]     = 16'hA000 + 16'(i);
            ref_mem[i] = 16'hA000 + 16'(i);
        end
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        r3_valid = 1'b0; r3_we = 1'b0; r3_addr = '0; r3_wdata = '0; r3_data_out = '0;
        #12;
        test_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_store_load();
        test_load_init();
        test_back_to_back();
        test_read_lat3();
        test_reset_mid();
        test_addr_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
